// File: rtl/hazard_stall_ctrl.sv
// Decode-stage sequencing controller: load-use stalls, branch flushes and external freeze.
// Optional perf counters (stall_cnt/flush_cnt) are built when HAZ_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES = 1
`ifdef HAZ_PERF_CNT_EN
    ,parameter int CNT_W = 16
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic       br_taken,
    input  logic       ext_stall,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idex_write,
    output logic       idex_bubble,
    output logic [1:0] ctrl_state
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam logic [1:0] ST_RUN        = 2'b00;
    localparam logic [1:0] ST_LOAD_STALL = 2'b01;
    localparam logic [1:0] ST_FLUSH      = 2'b10;
    localparam logic [1:0] ST_HOLD       = 2'b11;

    localparam int unsigned MAX_CYC = (STALL_CYCLES > FLUSH_CYCLES) ? STALL_CYCLES : FLUSH_CYCLES;
    localparam int unsigned REM_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

    localparam logic [REM_W-1:0] STALL_LOAD = REM_W'(STALL_CYCLES - 1);
    localparam logic [REM_W-1:0] FLUSH_LOAD = REM_W'(FLUSH_CYCLES - 1);
    localparam logic [REM_W-1:0] REM_ONE    = REM_W'(1);

    logic [1:0]       state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic             hz;

    always_comb begin
        hz = ex_memread && (ex_rt != 5'd0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

        state_d     = state_q;
        rem_d       = rem_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_bubble = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (ext_stall) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_write = 1'b0;
                    state_d    = ST_HOLD;
                    rem_d      = '0;
                end else if (hz) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    if (STALL_CYCLES > 1) begin
                        state_d = ST_LOAD_STALL;
                        rem_d   = STALL_LOAD;
                    end
                end else if (br_taken) begin
                    ifid_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        rem_d   = FLUSH_LOAD;
                    end
                end
            end

            // ID is frozen here, so a pending br_taken is simply seen again once back in RUN.
            ST_LOAD_STALL: begin
                if (ext_stall) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_write = 1'b0;
                    state_d    = ST_HOLD;
                    rem_d      = '0;
                end else begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    if (rem_q == REM_ONE) begin
                        state_d = ST_RUN;
                        rem_d   = '0;
                    end else begin
                        rem_d = rem_q - REM_ONE;
                    end
                end
            end

            ST_FLUSH: begin
                if (ext_stall) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_write = 1'b0;
                    state_d    = ST_HOLD;
                    rem_d      = '0;
                end else begin
                    ifid_flush = 1'b1;
                    if (rem_q == REM_ONE) begin
                        state_d = ST_RUN;
                        rem_d   = '0;
                    end else begin
                        rem_d = rem_q - REM_ONE;
                    end
                end
            end

            default: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_write = 1'b0;
                rem_d      = '0;
                if (!ext_stall) begin
                    state_d = ST_RUN;
                end
            end
        endcase

        // Reset forces a safe front end: nothing loads, IF/ID and ID/EX hold NOPs.
        if (!rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    assign ctrl_state = state_q;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (idex_bubble && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (ifid_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: two configurations driven in lockstep against
// a cycle-count reference model; perf counters checked when HAZ_PERF_CNT_EN is defined.
module tb_hazard_stall_ctrl;

    localparam int TB_CNT_W = 2;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_memread, br_taken, ext_stall;

    logic       a_pc, a_ifw, a_iff, a_idw, a_idb;
    logic [1:0] a_st;
    logic       b_pc, b_ifw, b_iff, b_idw, b_idb;
    logic [1:0] b_st;
`ifdef HAZ_PERF_CNT_EN
    logic [TB_CNT_W-1:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
`endif

    int checks   = 0;
    int failures = 0;

    hazard_stall_ctrl #(
        .STALL_CYCLES(1),
        .FLUSH_CYCLES(2)
`ifdef HAZ_PERF_CNT_EN
        ,.CNT_W(TB_CNT_W)
`endif
    ) dut_a (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .br_taken(br_taken), .ext_stall(ext_stall),
        .pc_write(a_pc), .ifid_write(a_ifw), .ifid_flush(a_iff), .idex_write(a_idw),
        .idex_bubble(a_idb), .ctrl_state(a_st)
`ifdef HAZ_PERF_CNT_EN
        ,.stall_cnt(a_scnt), .flush_cnt(a_fcnt)
`endif
    );

    hazard_stall_ctrl #(
        .STALL_CYCLES(3),
        .FLUSH_CYCLES(3)
`ifdef HAZ_PERF_CNT_EN
        ,.CNT_W(TB_CNT_W)
`endif
    ) dut_b (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .br_taken(br_taken), .ext_stall(ext_stall),
        .pc_write(b_pc), .ifid_write(b_ifw), .ifid_flush(b_iff), .idex_write(b_idw),
        .idex_bubble(b_idb), .ctrl_state(b_st)
`ifdef HAZ_PERF_CNT_EN
        ,.stall_cnt(b_scnt), .flush_cnt(b_fcnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: remaining stall / flush cycles and a hold flag per configuration.
    int m_stalls[2] = '{1, 3};
    int m_flushes[2] = '{2, 3};
    bit m_hold[2];
    int m_sl[2];
    int m_fl[2];
    int m_sc[2];
    int m_fc[2];

    // Packed as {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, ctrl_state}.
    function automatic logic [6:0] got(int d);
        if (d == 0) return {a_pc, a_ifw, a_iff, a_idw, a_idb, a_st};
        return {b_pc, b_ifw, b_iff, b_idw, b_idb, b_st};
    endfunction

    function automatic bit hz_ref();
        return ex_memread && (ex_rt != 0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

    function automatic logic [6:0] model_out(int d);
        logic [1:0] st;
        if (!rst) return 7'b0010100;
        if (m_hold[d]) return 7'b0000011;
        st = (m_sl[d] > 0) ? 2'b01 : ((m_fl[d] > 0) ? 2'b10 : 2'b00);
        if (ext_stall) return {5'b00000, st};
        if (m_sl[d] > 0) return {5'b00011, st};
        if (m_fl[d] > 0) return {5'b11110, st};
        if (hz_ref()) return {5'b00011, st};
        if (br_taken) return {5'b11110, st};
        return {5'b11010, st};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_hold[d] = 0; m_sl[d] = 0; m_fl[d] = 0; m_sc[d] = 0; m_fc[d] = 0;
        end
    endtask

    // Update the model with the inputs present before the edge, then step past the edge.
    task automatic advance();
        logic [6:0] o;
        int cmax;
        cmax = (1 << TB_CNT_W) - 1;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                o = model_out(d);
                if (o[2] && m_sc[d] < cmax) m_sc[d]++;
                if (o[4] && m_fc[d] < cmax) m_fc[d]++;
                if (m_hold[d]) begin
                    m_hold[d] = ext_stall; m_sl[d] = 0; m_fl[d] = 0;
                end else if (ext_stall) begin
                    m_hold[d] = 1; m_sl[d] = 0; m_fl[d] = 0;
                end else if (m_sl[d] > 0) m_sl[d]--;
                else if (m_fl[d] > 0) m_fl[d]--;
                else if (hz_ref()) m_sl[d] = m_stalls[d] - 1;
                else if (br_taken) m_fl[d] = m_flushes[d] - 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                          input logic mr, input logic [4:0] ert, input logic br, input logic ext);
        id_rs = rs; id_rt = rt; id_uses_rt = uses;
        ex_memread = mr; ex_rt = ert; br_taken = br; ext_stall = ext;
    endtask

    task automatic test_reset();
        #2;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (got(d) !== 7'b0010100) begin
                failures++;
                $display("FAIL reset_hold dut%0d got=%b exp=%b", d, got(d), 7'b0010100);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        set_in(5, 0, 0, 1, 5, 0, 0);
        #2;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (got(d) !== model_out(d)) begin
                failures++;
                $display("FAIL reset_pre_stall dut%0d got=%b exp=%b", d, got(d), model_out(d));
            end
        end
        advance();
        set_in(0, 0, 0, 0, 0, 0, 0);
        #2;
        checks++;
        if (b_st !== 2'b01) begin
            failures++;
            $display("FAIL reset_in_load_stall state got=%b exp=01", b_st);
        end
        rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({b_st, b_pc, b_iff, b_idb} !== 5'b00011) begin
            failures++;
            $display("FAIL reset_async {st,pc,flush,bubble} got=%b exp=00011",
                     {b_st, b_pc, b_iff, b_idb});
        end
        #1;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (got(d) !== 7'b1101000) begin
                failures++;
                $display("FAIL reset_release dut%0d got=%b exp=%b", d, got(d), 7'b1101000);
            end
        end
        advance();
    endtask

    task automatic test_load_use();
        set_in(5, 9, 0, 1, 5, 0, 0);
        #2;
        checks++;
        if ({a_pc, a_idb, a_idw, a_st} !== 5'b01100) begin
            failures++;
            $display("FAIL load_use_stall {pc,bubble,idw,st} got=%b exp=01100", {a_pc, a_idb, a_idw, a_st});
        end
        advance();
        set_in(5, 9, 0, 0, 5, 0, 0);
        for (int c = 0; c < 3; c++) begin
            #2;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (got(d) !== model_out(d)) begin
                    failures++;
                    $display("FAIL load_use_after dut%0d c%0d got=%b exp=%b", d, c, got(d), model_out(d));
                end
            end
            advance();
        end
        checks++;
        if (got(0) !== 7'b1101000) begin
            failures++;
            $display("FAIL load_use_normal got=%b exp=1101000", got(0));
        end
        set_in(0, 0, 1, 1, 0, 0, 0);
        #2;
        checks++;
        if ({a_pc, a_idb} !== 2'b10 || {b_pc, b_idb} !== 2'b10) begin
            failures++;
            $display("FAIL load_use_r0 a={pc,bub}=%b b=%b exp=10", {a_pc, a_idb}, {b_pc, b_idb});
        end
        advance();
    endtask

    task automatic test_rt_gating();
        set_in(1, 7, 0, 1, 7, 0, 0);
        #2;
        checks++;
        if ({a_pc, a_idb} !== 2'b10) begin
            failures++;
            $display("FAIL rt_unused {pc,bubble} got=%b exp=10", {a_pc, a_idb});
        end
        id_uses_rt = 1'b1;
        #1;
        checks++;
        if ({a_pc, a_idb} !== 2'b01) begin
            failures++;
            $display("FAIL rt_used {pc,bubble} got=%b exp=01", {a_pc, a_idb});
        end
        advance();
        set_in(0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) advance();
    endtask

    task automatic test_branch();
        logic [6:0] exp_a[3] = '{7'b1111000, 7'b1111010, 7'b1101000};
        set_in(0, 0, 0, 0, 0, 1, 0);
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++;
            if (got(0) !== exp_a[c]) begin
                failures++;
                $display("FAIL branch_seq c%0d got=%b exp=%b", c, got(0), exp_a[c]);
            end
            checks++;
            if (got(1) !== model_out(1)) begin
                failures++;
                $display("FAIL branch_b c%0d got=%b exp=%b", c, got(1), model_out(1));
            end
            advance();
            br_taken = 1'b0;
        end
        for (int c = 0; c < 2; c++) advance();
    endtask

    task automatic test_priority();
        set_in(3, 0, 0, 1, 3, 1, 0);
        #2;
        checks++;
        if ({a_iff, a_idb, a_pc} !== 3'b010) begin
            failures++;
            $display("FAIL prio_hz_br {flush,bubble,pc} got=%b exp=010", {a_iff, a_idb, a_pc});
        end
        advance();
        ex_memread = 1'b0;
        #2;
        checks++;
        if ({a_iff, a_idb, a_st} !== 4'b1000) begin
            failures++;
            $display("FAIL prio_flush_next {flush,bubble,st} got=%b exp=1000", {a_iff, a_idb, a_st});
        end
        checks++;
        if (got(1) !== model_out(1)) begin
            failures++;
            $display("FAIL prio_b got=%b exp=%b", got(1), model_out(1));
        end
        advance();
        br_taken = 1'b0;
        ext_stall = 1'b1;
        #2;
        checks++;
        if ({a_pc, a_ifw, a_idw, a_st} !== 5'b00010) begin
            failures++;
            $display("FAIL prio_ext_in_flush {pc,ifw,idw,st} got=%b exp=00010", {a_pc, a_ifw, a_idw, a_st});
        end
        advance();
        for (int c = 0; c < 3; c++) begin
            if (c == 1) ext_stall = 1'b0;
            #2;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (got(d) !== model_out(d)) begin
                    failures++;
                    $display("FAIL prio_hold dut%0d c%0d got=%b exp=%b", d, c, got(d), model_out(d));
                end
            end
            advance();
        end
        checks++;
        if (a_st !== 2'b00) begin
            failures++;
            $display("FAIL prio_hold_exit state got=%b exp=00", a_st);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0));
            #2;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (got(d) !== model_out(d)) begin
                    failures++;
                    $display("FAIL random dut%0d c%0d got=%b exp=%b", d, c, got(d), model_out(d));
                end
            end
`ifdef HAZ_PERF_CNT_EN
            checks++;
            if (int'(a_scnt) != m_sc[0] || int'(a_fcnt) != m_fc[0] ||
                int'(b_scnt) != m_sc[1] || int'(b_fcnt) != m_fc[1]) begin
                failures++;
                $display("FAIL random_cnt c%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", c,
                         a_scnt, a_fcnt, b_scnt, b_fcnt, m_sc[0], m_fc[0], m_sc[1], m_fc[1]);
            end
`endif
            advance();
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) advance();
    endtask

`ifdef HAZ_PERF_CNT_EN
    task automatic test_perf_sat();
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (a_scnt !== '0 || a_fcnt !== '0) begin
            failures++;
            $display("FAIL perf_reset got=%0d/%0d exp=0/0", a_scnt, a_fcnt);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        set_in(6, 0, 0, 1, 6, 0, 0);
        for (int c = 0; c < 5; c++) advance();
        set_in(0, 0, 0, 0, 0, 0, 0);
        #2;
        checks++;
        if (a_scnt !== 2'd3 || a_fcnt !== 2'd0) begin
            failures++;
            $display("FAIL perf_sat stall/flush got=%0d/%0d exp=3/0", a_scnt, a_fcnt);
        end
        advance();
    endtask
`endif

    initial begin
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_rt_gating();
        test_branch();
        test_priority();
        test_random();
`ifdef HAZ_PERF_CNT_EN
        test_perf_sat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
